rc5_key_schedule: RTL
=====================

# rc5_key_schedule

Parametrised RC5 key-expansion engine. On a start pulse it captures a secret key, fills the external S RAM with the magic-constant progression, then runs the full 3·max(T,C) mixing loop that folds the key words L into S, writing every S update back through a single RAM port. It sits between key ingress and the RC5 round datapath, which reads the finished S table from the same RAM. Word width, round count and key length are parameters.

## Interface
- W, 32: word width in bits; power of two, 16/32/64.
- R, 12: round count; T = 2(R+1) S words.
- B, 16: key length in bytes, ≥1; C = max(1, ceil(B/(W/8))) L words.
- PW, 32'hB7E15163: magic constant P_w (W bits).
- QW, 32'h9E3779B9: magic constant Q_w (W bits).
- T_LENGTH, $clog2(T): S address width (derived).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- iStart  in  1  start request, sampled only in IDLE.
- iKey  in  8·B  key; byte k = iKey[8k+7:8k]; captured on accepted iStart.
- iS_data  in  W  S RAM read data; valid one cycle after address is presented (registered-read RAM).
- oS_address  out  T_LENGTH  S RAM address.
- oS_data  out  W  S RAM write data.
- oS_we  out  1  S RAM write enable.
- oBusy  out  1  high from the cycle after acceptance through the last write.
- oDone  out  1  one-cycle completion pulse.

## Operation
- Reset: state IDLE; oS_we=0, oS_address=0, oS_data=0, oBusy=0, oDone=0; A, B, i, j, counters cleared.
- L load on accept: L[m] = iKey[W·m +: W] (little-endian bytes); bytes past 8·B in the last word are zero.
- States: IDLE → INIT → MIX_RD ↔ MIX_WR → DONE → IDLE.
- IDLE: iStart=1 captures the key, clears accumulator to PW, goes to INIT.
- INIT: one write per cycle, address i=0..T-1, data S[i]=PW+i·QW mod 2^W; after i=T-1 go to MIX_RD with A=B=0, i=j=0, iteration count n=0.
- MIX_RD: drive oS_address=i, oS_we=0; go to MIX_WR.
- MIX_WR: A' = rotl(iS_data+A+B, 3); write S[i]=A' (oS_we=1, oS_address=i); B' = rotl(L[j]+A'+B, (A'+B) mod W); L[j]←B'; A←A', B←B'; i←(i+1) mod T, j←(j+1) mod C; n←n+1; if n = 3·max(T,C) go to DONE, else MIX_RD.
- DONE: oDone=1 one cycle, oBusy=0, return IDLE. S RAM holds the final table.
- All additions modulo 2^W; rotate amount is the low log2(W) bits.
- iStart outside IDLE is ignored; iKey changes after acceptance have no effect.
- rst mid-operation: immediate return to IDLE with reset outputs; S RAM contents are partial and invalid; no oDone.

## Timing
- iStart accepted at edge k: INIT writes in cycles k+1..k+T.
- Mixing: 2 cycles/iteration, N=3·max(T,C); last write in cycle k+T+2N; oDone in cycle k+T+2N+1.
- Defaults (T=26, C=4, N=78): oDone at k+183.
- No read-after-write hazard: read of i+1 follows write of i (T≥2); wrap T-1→0 also distinct.
- oS_data/oS_address hold their last value on non-write cycles; oS_we high only in INIT and MIX_WR.
- Back-to-back: a new iStart is accepted in the IDLE cycle immediately after oDone.

## Test plan
- INIT check (defaults, stop before mixing via RAM monitor): writes S[0]=B7E15163, S[1]=5618CB1C, S[2]=F45044D5 at cycles k+1..k+3.
- Zero key, defaults: first MIX_WR writes S[0]=BF0A8B1D; internal L[0] becomes B7E15163; oDone exactly at k+183; final S matches golden C model (and RC5-32/12/16 zero-key encrypts 0 to 21A5DBEE 154B8F6D).
- Small config W=16, R=1, B=2, PW=B7E1, QW=9E37: T=4, C=1, N=12; oDone at k+29; S equals model.
- Odd key length W=32, B=5: upper 3 bytes of L[1] zero; C=2; S equals model.
- iStart pulsed during MIX and iKey toggled after acceptance: no restart, result equals model for captured key.
- rst asserted at cycle k+50: next cycle all outputs zero, no oDone; fresh iStart yields correct table and oDone at new k'+183.

Source files
------------

// File: rtl/rc5_key_schedule.sv
// rc5_key_schedule: RC5 key-expansion engine.
// On an accepted start it captures the key into the L words, fills the
// external S RAM with P_w + i*Q_w, then runs 3*max(T,C) mixing iterations,
// each one a RAM read (MIX_RD) followed by a write-back (MIX_WR).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   iStart, iKey      start request (IDLE only) and key, byte k = iKey[8k+:8]
//   iS_data           S RAM read data, valid one cycle after the address
//   oS_address        S RAM address
//   oS_data, oS_we    S RAM write data / write enable
//   oBusy, oDone      busy flag, one-cycle completion pulse
module rc5_key_schedule #(
    parameter int            W        = 32,
    parameter int            R        = 12,
    parameter int            B        = 16,
    parameter logic [W-1:0]  PW       = 32'hB7E15163,
    parameter logic [W-1:0]  QW       = 32'h9E3779B9,
    parameter int            T_LENGTH = $clog2(2*(R+1))
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iStart,
    input  logic [8*B-1:0]      iKey,
    input  logic [W-1:0]        iS_data,
    output logic [T_LENGTH-1:0] oS_address,
    output logic [W-1:0]        oS_data,
    output logic                oS_we,
    output logic                oBusy,
    output logic                oDone
);
    localparam int T  = 2*(R+1);
    localparam int U  = W/8;
    localparam int C  = (B + U - 1) / U;
    localparam int N  = 3 * ((T > C) ? T : C);
    localparam int LW = $clog2(W);
    localparam int JW = (C > 1) ? $clog2(C) : 1;
    localparam int NW = $clog2(N);

    typedef enum logic [2:0] {IDLE, INIT, MIX_RD, MIX_WR, DONE} state_t;

    state_t               state, state_next;
    logic [T_LENGTH-1:0]  i;
    logic [JW-1:0]        j;
    logic [NW-1:0]        n;
    logic [W-1:0]         a, b, acc;
    logic [C-1:0][W-1:0]  l;
    logic [T_LENGTH-1:0]  addr_q;
    logic [W-1:0]         data_q;

    // Key zero-extended to a whole number of words; unused top bytes stay 0.
    logic [C*W-1:0]       key_pad;
    always_comb begin
        key_pad = '0;
        key_pad[8*B-1:0] = iKey;
    end

    // Mixing datapath: iS_data is the S[i] read issued in the previous MIX_RD.
    logic [W-1:0]   sum_a, a_new, ab, sum_b, b_new;
    logic [2*W-1:0] rot_b;
    always_comb begin
        sum_a = iS_data + a + b;
        a_new = {sum_a[W-4:0], sum_a[W-1:W-3]};
        ab    = a_new + b;
        sum_b = l[j] + ab;
        // Upper half of {x,x} << s is rotl(x, s).
        rot_b = {sum_b, sum_b} << ab[LW-1:0];
        b_new = rot_b[2*W-1:W];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Address/data fall back to the held registers so they keep their last
    // value on cycles that do not write.
    always_comb begin
        state_next = state;
        oS_we      = 1'b0;
        oS_address = addr_q;
        oS_data    = data_q;
        oBusy      = 1'b0;
        oDone      = 1'b0;
        case (state)
            IDLE:    if (iStart) state_next = INIT;
            INIT: begin
                oBusy      = 1'b1;
                oS_we      = 1'b1;
                oS_address = i;
                oS_data    = acc;
                if (i == T_LENGTH'(T-1)) state_next = MIX_RD;
            end
            MIX_RD: begin
                oBusy      = 1'b1;
                oS_address = i;
                state_next = MIX_WR;
            end
            MIX_WR: begin
                oBusy      = 1'b1;
                oS_we      = 1'b1;
                oS_address = i;
                oS_data    = a_new;
                state_next = (n == NW'(N-1)) ? DONE : MIX_RD;
            end
            DONE: begin
                oDone      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i      <= '0;
            j      <= '0;
            n      <= '0;
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            l      <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            addr_q <= oS_address;
            data_q <= oS_data;
            case (state)
                IDLE: if (iStart) begin
                    l   <= key_pad;
                    acc <= PW;
                    i   <= '0;
                end
                INIT: begin
                    acc <= acc + QW;
                    if (i == T_LENGTH'(T-1)) begin
                        i <= '0;
                        j <= '0;
                        n <= '0;
                        a <= '0;
                        b <= '0;
                    end else begin
                        i <= i + T_LENGTH'(1);
                    end
                end
                MIX_WR: begin
                    a    <= a_new;
                    b    <= b_new;
                    l[j] <= b_new;
                    i    <= (i == T_LENGTH'(T-1)) ? '0 : i + T_LENGTH'(1);
                    j    <= (j == JW'(C-1)) ? '0 : j + JW'(1);
                    n    <= n + NW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
